// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, major opcodes,
// ALU operand selects and ALU operation codes.
package riscv_pkg;

   localparam int STATE_BITS = 4;

   typedef enum logic [STATE_BITS-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_TRAP      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [1:0] SRCA_RD1    = 2'b10;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // States that wait on the shared memory strobe and are covered by the timeout.
   function automatic logic is_mem_wait(state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore-decoded multicycle RISC-V control FSM; ALU 4, branch 3, store 4, load 5 cycles with zero memory wait.
// Memory states stall on mem_ready and trap (bus_err) after MEM_TIMEOUT idle cycles; illegal opcodes trap.
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               i_or_d,
   output logic               pc_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               instr_done,
   output logic               trap,
   output logic               bus_err,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             timeout;

   assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
            // A ready strobe on the timeout cycle still counts as progress.
            if (mem_ready) begin
               case (state_q)
                  S_FETCH:    state_d = S_DECODE;
                  S_MEM_READ: state_d = S_MEM_WB;
                  default:    state_d = S_FETCH;
               endcase
            end else if (timeout) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:         state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
         S_TRAP:             state_d = S_TRAP;
         default:            state_d = S_TRAP;
      endcase

      if (state_d != state_q)
         cnt_d = '0;
      else if (is_mem_wait(state_q) && !mem_ready)
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      i_or_d     = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      trap       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // Reset holds the FSM in FETCH; keep its write strobes quiet meanwhile.
            ir_write  = mem_ready & rst;
            pc_write  = mem_ready & rst;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM_SH;
         end
         S_MEM_ADDR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC_R: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RD1;
            alu_op     = ALUOP_SUB;
            pc_src     = 1'b1;
            pc_write   = zero;
            instr_done = 1'b1;
         end
         S_TRAP:  trap = 1'b1;
         default: trap = 1'b1;
      endcase
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle plans built from the
// instruction-class state sequences and per-state output table, driven with random waits.
module tb_multicycle_ctrl;
   import riscv_pkg::*;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, i_or_d, pc_src;
   logic [1:0] alu_src_a, alu_src_b, alu_op;
   logic       instr_done, trap, bus_err, illegal;
   logic [3:0] state;
   logic [17:0] dut_outs;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      state_e      st;
      logic [6:0]  opc;
      logic        rdy;
      logic        zr;
      logic [17:0] outs;
   } cyc_t;

   cyc_t plan[$];

   multicycle_ctrl #(.MEM_TIMEOUT(15), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .i_or_d(i_or_d), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .instr_done(instr_done), .trap(trap), .bus_err(bus_err),
      .illegal(illegal), .state(state)
   );

   assign dut_outs = {pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, i_or_d,
                      pc_src, alu_src_a, alu_src_b, alu_op, instr_done, trap, bus_err, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-state output table, in the same bit order as dut_outs.
   function automatic logic [17:0] exp_out(state_e st, logic rdy, logic zr, logic ill, logic berr);
      logic pcw, irw, rw, mr, mw, m2r, iod, pcs, done, trp;
      logic [1:0] a, b, op;
      {pcw, irw, rw, mr, mw, m2r, iod, pcs, done, trp} = '0;
      a = 2'b00; b = 2'b00; op = 2'b00;
      case (st)
         S_FETCH:     begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE:    begin a = 2'b01; b = 2'b11; end
         S_MEM_ADDR:  begin a = 2'b10; b = 2'b10; end
         S_MEM_READ:  begin mr = 1; iod = 1; end
         S_MEM_WB:    begin rw = 1; m2r = 1; done = 1; end
         S_MEM_WRITE: begin mw = 1; iod = 1; done = rdy; end
         S_EXEC_R:    begin a = 2'b10; op = 2'b10; end
         S_EXEC_I:    begin a = 2'b10; b = 2'b10; op = 2'b10; end
         S_ALU_WB:    begin rw = 1; done = 1; end
         S_BRANCH:    begin a = 2'b10; op = 2'b01; pcs = 1; pcw = zr; done = 1; end
         default:     trp = 1;
      endcase
      return {pcw, irw, rw, mr, mw, m2r, iod, pcs, a, b, op, done, trp, berr, ill};
   endfunction

   task automatic push(state_e st, logic [6:0] opc, logic rdy, logic zr, logic ill, logic berr);
      cyc_t c;
      c.st = st; c.opc = opc; c.rdy = rdy; c.zr = zr;
      c.outs = exp_out(st, rdy, zr, ill, berr);
      plan.push_back(c);
   endtask

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   // A memory phase: w idle cycles followed by one ready cycle.
   task automatic push_wait(state_e st, logic [6:0] opc, int w);
      for (int i = 0; i < w; i++) push(st, opc, 1'b0, rbit(), 1'b0, 1'b0);
      push(st, opc, 1'b1, rbit(), 1'b0, 1'b0);
   endtask

   task automatic add_instr(logic [6:0] opc, logic zr, int wf, int wm);
      push_wait(S_FETCH, opc, wf);
      push(S_DECODE, opc, rbit(), rbit(), 1'b0, 1'b0);
      case (opc)
         OP_LOAD: begin
            push(S_MEM_ADDR, opc, rbit(), rbit(), 1'b0, 1'b0);
            push_wait(S_MEM_READ, opc, wm);
            push(S_MEM_WB, opc, rbit(), rbit(), 1'b0, 1'b0);
         end
         OP_STORE: begin
            push(S_MEM_ADDR, opc, rbit(), rbit(), 1'b0, 1'b0);
            push_wait(S_MEM_WRITE, opc, wm);
         end
         OP_RTYPE: begin
            push(S_EXEC_R, opc, rbit(), rbit(), 1'b0, 1'b0);
            push(S_ALU_WB, opc, rbit(), rbit(), 1'b0, 1'b0);
         end
         OP_ITYPE: begin
            push(S_EXEC_I, opc, rbit(), rbit(), 1'b0, 1'b0);
            push(S_ALU_WB, opc, rbit(), rbit(), 1'b0, 1'b0);
         end
         default: push(S_BRANCH, opc, rbit(), zr, 1'b0, 1'b0);
      endcase
   endtask

   // Drive one planned cycle's inputs and move to the sampling point.
   task automatic apply(input cyc_t c);
      opcode = c.opc; zero = c.zr; mem_ready = c.rdy;
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; opcode = OP_RTYPE; zero = 1'b1; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (state !== 4'(S_FETCH) || dut_outs !== exp_out(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL reset: state=%0d outs=%h required state=%0d outs=%h",
                  state, dut_outs, S_FETCH, exp_out(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_rtype();
      int dones = 0;
      cyc_t c;
      add_instr(OP_RTYPE, 1'b0, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         dones += int'(instr_done);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL rtype: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
      n_cmp++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL rtype_done_pulses: got %0d required 1", dones);
      end
   endtask

   task automatic test_load_wait();
      int cyc = 0, done_at = 0;
      cyc_t c;
      add_instr(OP_LOAD, 1'b0, 0, 3);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         cyc++;
         if (instr_done && done_at == 0) done_at = cyc;
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL load_wait: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
      n_cmp++;
      if (done_at !== 8) begin
         n_fail++;
         $display("FAIL load_latency: retired on cycle %0d required 8", done_at);
      end
   endtask

   task automatic test_branch();
      cyc_t c;
      add_instr(OP_BRANCH, 1'b1, 0, 0);
      add_instr(OP_BRANCH, 1'b0, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL branch: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [5];
      int n_instr = 80, dones = 0, wf, wm;
      cyc_t c;
      ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_RTYPE; ops[3] = OP_ITYPE; ops[4] = OP_BRANCH;
      for (int i = 0; i < n_instr; i++) begin
         wf = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
         wm = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
         add_instr(ops[$urandom_range(0, 4)], rbit(), wf, wm);
      end
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         dones += int'(instr_done);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL back_to_back: state=%0d outs=%h required state=%0d outs=%h opc=%b",
                     state, dut_outs, c.st, c.outs, c.opc);
         end
         advance();
      end
      n_cmp++;
      if (dones !== n_instr) begin
         n_fail++;
         $display("FAIL back_to_back_retired: got %0d required %0d", dones, n_instr);
      end
   endtask

   task automatic test_illegal();
      cyc_t c;
      push(S_FETCH, 7'h7F, 1'b1, rbit(), 1'b0, 1'b0);
      push(S_DECODE, 7'h7F, rbit(), rbit(), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) push(S_TRAP, 7'h7F, rbit(), rbit(), 1'b1, 1'b0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL illegal: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
      // Asynchronous reset between edges must clear the sticky flag at once.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (state !== 4'(S_FETCH) || illegal !== 1'b0 || trap !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_async_reset: state=%0d illegal=%b trap=%b required state=%0d 0 0",
                  state, illegal, trap, S_FETCH);
      end
      hold_reset();
   endtask

   task automatic test_timeout();
      cyc_t c;
      for (int i = 0; i < 16; i++) push(S_FETCH, OP_RTYPE, 1'b0, rbit(), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push(S_TRAP, OP_RTYPE, rbit(), rbit(), 1'b0, 1'b1);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL timeout_trap: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
      hold_reset();
      // Ready on the last permitted cycle wins over the timeout.
      add_instr(OP_RTYPE, 1'b0, 15, 0);
      add_instr(OP_STORE, 1'b0, 0, 15);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL timeout_edge: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_write();
      cyc_t c;
      add_instr(OP_STORE, 1'b0, 0, 10);
      for (int k = 0; k < 5; k++) begin
         c = plan.pop_front();
         apply(c);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL mid_write_pre: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
      plan.delete();
      mem_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (state !== 4'(S_FETCH) || dut_outs !== exp_out(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL mid_write_reset: state=%0d outs=%h required state=%0d outs=%h",
                  state, dut_outs, S_FETCH, exp_out(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      hold_reset();
      add_instr(OP_ITYPE, 1'b0, 1, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         apply(c);
         n_cmp++;
         if (state !== 4'(c.st) || dut_outs !== c.outs) begin
            n_fail++;
            $display("FAIL after_reset: state=%0d outs=%h required state=%0d outs=%h", state, dut_outs, c.st, c.outs);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load_wait();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles a memory state waits for mem_ready before trapping.
REQ-002 SHALL have parameter STATE_W, default 4, width of the state encoding.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port opcode  input  7  ix[6:0] of the instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  unified memory completion strobe.
REQ-008 SHALL have port pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, i_or_d, pc_src  output  1 each  datapath strobes and selects.
REQ-009 SHALL have port alu_src_a  output  2  00 PC, 01 oldPC, 10 rd1.
REQ-010 SHALL have port alu_src_b  output  2  00 rd2, 01 const 4, 10 imm, 11 imm<<1.
REQ-011 SHALL have port alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-012 SHALL have ports instr_done (1: retire pulse), trap (1), bus_err (1), illegal (1) and state (STATE_W), all outputs.

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP; all unlisted outputs 0 in every state.
REQ-014 FETCH: mem_read=1, i_or_d=0, a=00, b=01, op=00; ir_write=pc_write=mem_ready; ->DECODE on mem_ready, else hold.
REQ-015 DECODE: a=01, b=11, op=00 (branch target to ALUOut); next by opcode: 0000011/0100011->MEM_ADDR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, other->TRAP with illegal=1.
REQ-016 MEM_ADDR: a=10, b=10, op=00; ->MEM_READ if load, MEM_WRITE if store.
REQ-017 MEM_READ: mem_read=1, i_or_d=1; ->MEM_WB on mem_ready. MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1; ->FETCH.
REQ-018 MEM_WRITE: mem_write=1, i_or_d=1; on mem_ready instr_done=1 and ->FETCH.
REQ-019 EXEC_R: a=10, b=00, op=10; EXEC_I: a=10, b=10, op=10; both ->ALU_WB. ALU_WB: reg_write=1, instr_done=1; ->FETCH.
REQ-020 BRANCH: a=10, b=00, op=01, pc_src=1, pc_write=zero, instr_done=1; ->FETCH.
REQ-021 TRAP: absorbing; trap=1; no strobes asserted; exit only via reset.
REQ-022 Wait counter, width clog2(MEM_TIMEOUT+1), SHALL clear on entry to FETCH/MEM_READ/MEM_WRITE and increment each cycle there with mem_ready=0.
REQ-023 When counter equals MEM_TIMEOUT and mem_ready=0, next state SHALL be TRAP with bus_err=1; mem_ready=1 on that same cycle wins (normal progress).
REQ-024 mem_ready outside FETCH/MEM_READ/MEM_WRITE SHALL be ignored.
REQ-025 illegal and bus_err SHALL be sticky until reset, mutually exclusive.
REQ-026 Latencies with mem_ready=1 immediately: R/I-ALU 4 cycles, branch 3, store 4, load 5.

Reset
REQ-027 rst=0 SHALL asynchronously force state=FETCH, counter=0, illegal=bus_err=0.
REQ-028 Since outputs are Moore-decoded, during reset the FETCH outputs (mem_read=1, a=00, b=01) SHALL appear with ir_write=pc_write gated low while rst=0.
REQ-029 Reset mid-wait or mid-instruction SHALL abandon the instruction; no write strobe after rst asserts.

Structure
REQ-030 State encodings, opcode constants, ALU-select and alu_op encodings SHALL live in shared package riscv_pkg.
REQ-031 Single module; no sub-module (next-state and output decode are two combinational blocks plus one state register).

Verification
REQ-032 add x3,x1,x2 (0110011), mem_ready=1 always -> states FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 only in cycle 4; instr_done one pulse.
REQ-033 lw (0000011), mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=1; total 8 cycles.
REQ-034 beq with zero=1 then zero=0 -> BRANCH pc_write=1,pc_src=1 first; pc_write=0 second.
REQ-035 opcode 1111111 -> TRAP after DECODE, illegal=1, held 20 cycles with all strobes 0.
REQ-036 mem_ready=0 forever in FETCH, MEM_TIMEOUT=15 -> TRAP entered on cycle 16, bus_err=1; repeat with mem_ready=1 on cycle 16 -> DECODE.
REQ-037 rst=0 asserted mid-MEM_WRITE wait -> state=FETCH asynchronously, mem_write=0 immediately, flags cleared.
